// File: rtl/lpc_host.sv
// LPC I/O and memory cycle initiator; optional LPC_HOST_SYNC_TIMEOUT_EN bounds long-wait SYNCs at SYNC_TIMEOUT.
// Latency: START the cycle after acceptance, resp_valid 13 (I/O) / 17 (memory) edges after it plus SYNC waits.
// Backpressure: req_ready is low from the cycle after acceptance until the cycle after DONE.
module lpc_host #(
    parameter int SYNC_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cyctype_dir,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_data,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    input  logic [3:0]  lpc_ad_in,
    output logic        lpc_frame,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic        resp_error
);
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_CYCTYPE, S_ADDR, S_WDATA, S_TAR_H,
        S_TAR_P, S_SYNC, S_RDATA, S_TAR_B, S_ABORT, S_DONE
    } state_t;

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [1:0]  miss, miss_n;
    logic [2:0]  cyc_q;
    logic [31:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  data_n;
    logic        err_n;
    logic [3:0]  ad_n;
    logic        oe_n, frame_n;
    logic [2:0]  nib;
    logic        is_mem, is_write, accept;
    logic        unused_rsvd;

`ifdef LPC_HOST_SYNC_TIMEOUT_EN
    logic [4:0]  lwait, lwait_n;
`else
    localparam int unused_sync_timeout = SYNC_TIMEOUT;
`endif

    assign is_mem      = cyc_q[1];
    assign is_write    = cyc_q[0];
    assign accept      = req_valid && req_ready;
    assign unused_rsvd = req_cyctype_dir[0];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        miss_n  = miss;
        data_n  = resp_data;
        err_n   = resp_error;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
        lwait_n = lwait;
`endif
        case (state)
            S_IDLE: if (accept) begin
                cnt_n   = 3'd0;
                data_n  = 8'h00;
                err_n   = req_cyctype_dir[3];
                state_n = req_cyctype_dir[3] ? S_DONE : S_START;
            end
            S_START:   state_n = S_CYCTYPE;
            S_CYCTYPE: begin
                state_n = S_ADDR;
                cnt_n   = 3'd0;
            end
            S_ADDR: if (cnt == (is_mem ? 3'd7 : 3'd3)) begin
                cnt_n   = 3'd0;
                state_n = is_write ? S_WDATA : S_TAR_H;
            end else begin
                cnt_n = cnt + 3'd1;
            end
            S_WDATA: if (cnt[0]) state_n = S_TAR_H;
                     else cnt_n = cnt + 3'd1;
            S_TAR_H: state_n = S_TAR_P;
            S_TAR_P: begin
                state_n = S_SYNC;
                miss_n  = 2'd0;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
                lwait_n = 5'd0;
`endif
            end
            S_SYNC: begin
                cnt_n = 3'd0;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
                lwait_n = 5'd0;
`endif
                case (lpc_ad_in)
                    4'b0000, 4'b1010: begin
                        err_n   = resp_error | (lpc_ad_in == 4'b1010);
                        state_n = is_write ? S_TAR_B : S_RDATA;
                    end
                    4'b0101: miss_n = 2'd0;
                    4'b0110: begin
                        miss_n = 2'd0;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
                        lwait_n = lwait + 5'd1;
                        if (int'(lwait) + 1 >= SYNC_TIMEOUT) begin
                            state_n = S_ABORT;
                            err_n   = 1'b1;
                        end
`endif
                    end
                    // anything unrecognised counts as nobody answering
                    default: if (miss == 2'd2) begin
                        state_n = S_ABORT;
                        err_n   = 1'b1;
                    end else begin
                        miss_n = miss + 2'd1;
                    end
                endcase
            end
            S_RDATA: if (cnt[0]) begin
                data_n[7:4] = lpc_ad_in;
                cnt_n       = 3'd0;
                state_n     = S_TAR_B;
            end else begin
                data_n[3:0] = lpc_ad_in;
                cnt_n       = 3'd1;
            end
            S_TAR_B: if (cnt[0]) state_n = S_DONE;
                     else cnt_n = 3'd1;
            S_ABORT: if (cnt == 3'd4) state_n = S_DONE;
                     else cnt_n = cnt + 3'd1;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // pin values are decoded from the next state so they leave the flops aligned with it
        ad_n    = 4'hF;
        oe_n    = 1'b0;
        frame_n = 1'b1;
        nib     = is_mem ? ~cnt_n : {1'b0, ~cnt_n[1:0]};
        case (state_n)
            S_START: begin
                frame_n = 1'b0;
                ad_n    = 4'h0;
                oe_n    = 1'b1;
            end
            S_CYCTYPE: begin
                ad_n = {cyc_q, 1'b0};
                oe_n = 1'b1;
            end
            S_ADDR: begin
                ad_n = addr_q[{nib, 2'b00} +: 4];
                oe_n = 1'b1;
            end
            S_WDATA: begin
                ad_n = cnt_n[0] ? wdata_q[7:4] : wdata_q[3:0];
                oe_n = 1'b1;
            end
            S_TAR_H: oe_n = 1'b1;
            S_ABORT: if (cnt_n != 3'd4) begin
                frame_n = 1'b0;
                oe_n    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            miss       <= 2'd0;
            cyc_q      <= 3'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 8'h00;
            req_ready  <= 1'b1;
            lpc_frame  <= 1'b1;
            lpc_ad_oe  <= 1'b0;
            lpc_ad_out <= 4'hF;
            resp_valid <= 1'b0;
            resp_data  <= 8'h00;
            resp_error <= 1'b0;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
            lwait      <= 5'd0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            miss       <= miss_n;
            if (accept) begin
                cyc_q   <= req_cyctype_dir[3:1];
                addr_q  <= req_addr;
                wdata_q <= req_data;
            end
            req_ready  <= (state_n == S_IDLE);
            lpc_frame  <= frame_n;
            lpc_ad_oe  <= oe_n;
            lpc_ad_out <= ad_n;
            resp_valid <= (state_n == S_DONE);
            resp_data  <= data_n;
            resp_error <= err_n;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
            lwait      <= lwait_n;
`endif
        end
    end
endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: directed scenarios plus randomized requests against a cycle-list reference model.
module tb_lpc_host;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cyctype_dir;
    logic [31:0] req_addr;
    logic [7:0]  req_data;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic [3:0]  lpc_ad_in;
    logic        lpc_frame;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        resp_error;

    always #5 clock = ~clock;

    lpc_host dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cyctype_dir(req_cyctype_dir), .req_addr(req_addr), .req_data(req_data),
        .lpc_ad_out(lpc_ad_out), .lpc_ad_oe(lpc_ad_oe), .lpc_ad_in(lpc_ad_in),
        .lpc_frame(lpc_frame),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error)
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // one entry per bus cycle after acceptance; ctl = {frame, oe, req_ready, resp_valid}
    typedef struct packed {
        logic [3:0] ctl;
        logic       drive;
        logic [3:0] ad;
    } cyc_t;

    cyc_t       exp_q[$];
    logic [3:0] in_q[$];
    logic [3:0] force_q[$];
    logic [7:0] exp_data;
    logic       exp_err;

    function automatic void push(input logic [3:0] ctl, input logic drive,
                                 input logic [3:0] ad, input logic [3:0] in_nib);
        cyc_t e;
        e.ctl   = ctl;
        e.drive = drive;
        e.ad    = ad;
        exp_q.push_back(e);
        in_q.push_back(in_nib);
    endfunction

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [3:0] pick_sync(input int k);
        int r;
        logic [3:0] v;
        if (force_q.size() > 0) return force_q.pop_front();
        if (k >= 12) return 4'h0;
        r = $urandom_range(0, 9);
        if (r < 4)       v = 4'h0;
        else if (r == 4) v = 4'hA;
        else if (r == 5) v = 4'h5;
        else if (r == 6) v = 4'h6;
        else if (r == 7) v = 4'hF;
        else begin
            v = rnd4();
            if (v == 4'h0 || v == 4'h5 || v == 4'h6 || v == 4'hA) v = 4'h3;
        end
        return v;
    endfunction

    // expected pin trace, peripheral replies and response for one request
    task automatic build(input logic [3:0] ct, input logic [31:0] a,
                         input logic [7:0] d, input logic [7:0] rd);
        int nadr;
        int misses;
        int outcome;
        logic [3:0] s;
        exp_q.delete();
        in_q.delete();
        exp_data = 8'h00;
        exp_err  = 1'b0;
        if (ct[3]) begin
            exp_err = 1'b1;
        end else begin
            push(4'b0100, 1'b1, 4'h0, rnd4());
            push(4'b1100, 1'b1, {ct[3:1], 1'b0}, rnd4());
            nadr = ct[2] ? 8 : 4;
            for (int i = nadr - 1; i >= 0; i--) push(4'b1100, 1'b1, a[4*i +: 4], rnd4());
            if (ct[1]) begin
                push(4'b1100, 1'b1, d[3:0], rnd4());
                push(4'b1100, 1'b1, d[7:4], rnd4());
            end
            push(4'b1100, 1'b1, 4'hF, rnd4());
            push(4'b1000, 1'b0, 4'hF, rnd4());
            misses  = 0;
            outcome = 0;
            for (int k = 0; k < 64 && outcome == 0; k++) begin
                s = pick_sync(k);
                push(4'b1000, 1'b0, 4'hF, s);
                if (s == 4'h0) outcome = 1;
                else if (s == 4'hA) begin
                    outcome = 1;
                    exp_err = 1'b1;
                end else if (s == 4'h5 || s == 4'h6) misses = 0;
                else begin
                    misses++;
                    if (misses == 3) outcome = 2;
                end
            end
            if (outcome == 2) begin
                repeat (4) push(4'b0100, 1'b1, 4'hF, rnd4());
                push(4'b1000, 1'b0, 4'hF, rnd4());
                exp_err = 1'b1;
            end else begin
                if (!ct[1]) begin
                    push(4'b1000, 1'b0, 4'hF, rd[3:0]);
                    push(4'b1000, 1'b0, 4'hF, rd[7:4]);
                    exp_data = rd;
                end
                push(4'b1000, 1'b0, 4'hF, rnd4());
                push(4'b1000, 1'b0, 4'hF, rnd4());
            end
        end
        push(4'b1001, 1'b0, 4'hF, rnd4());
        push(4'b1010, 1'b0, 4'hF, rnd4());
    endtask

    // lat_edges: clock edges from the accepting edge to the one that raises resp_valid; -1 skips
    task automatic run_txn(input string name, input logic [3:0] ct, input logic [31:0] a,
                           input logic [7:0] d, input logic [7:0] rd, input int lat_edges);
        int seen;
        build(ct, a, d, rd);
        check({name, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid       = 1'b1;
        req_cyctype_dir = ct;
        req_addr        = a;
        req_data        = d;
        seen            = -1;
        for (int t = 0; t < exp_q.size(); t++) begin
            @(negedge clock);
            if (t == 0) begin
                req_valid       = 1'b0;
                req_cyctype_dir = rnd4();
                req_addr        = $urandom;
                req_data        = 8'($urandom_range(0, 255));
            end
            check($sformatf("%s.ctl@%0d", name, t + 1),
                  {28'd0, lpc_frame, lpc_ad_oe, req_ready, resp_valid}, {28'd0, exp_q[t].ctl});
            if (exp_q[t].drive)
                check($sformatf("%s.ad@%0d", name, t + 1), {28'd0, lpc_ad_out}, {28'd0, exp_q[t].ad});
            if (exp_q[t].ctl[0]) begin
                check({name, ".data"}, {24'd0, resp_data}, {24'd0, exp_data});
                check({name, ".err"}, {31'd0, resp_error}, {31'd0, exp_err});
            end
            if (resp_valid && seen < 0) seen = t + 1;
            lpc_ad_in = in_q[t];
        end
        if (lat_edges >= 0) check({name, ".latency"}, seen - 1, lat_edges);
    endtask

    task automatic check_reset_values(input string name);
        check({name, ".ready"}, {31'd0, req_ready}, 32'd1);
        check({name, ".frame"}, {31'd0, lpc_frame}, 32'd1);
        check({name, ".oe"},    {31'd0, lpc_ad_oe}, 32'd0);
        check({name, ".ad"},    {28'd0, lpc_ad_out}, 32'hF);
        check({name, ".valid"}, {31'd0, resp_valid}, 32'd0);
        check({name, ".data"},  {24'd0, resp_data}, 32'd0);
        check({name, ".err"},   {31'd0, resp_error}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] ct;
        int u;
        reset           = 1'b0;
        req_valid       = 1'b0;
        req_cyctype_dir = 4'h0;
        req_addr        = 32'h0;
        req_data        = 8'h00;
        lpc_ad_in       = 4'hF;
        repeat (2) @(negedge clock);
        check_reset_values("por");
        reset = 1'b1;

        force_q = '{4'h0};
        run_txn("io_wr", 4'b0010, 32'h0000_0080, 8'hA5, 8'h00, 13);
        force_q = '{4'h6, 4'h6, 4'h0};
        run_txn("mem_rd", 4'b0100, 32'hFFFF_FFF0, 8'h00, 8'hC3, 19);
        force_q = '{4'h0};
        run_txn("mem_wr", 4'b0110, 32'h1234_5678, 8'h3C, 8'h00, 17);
        force_q = '{4'h0};
        run_txn("io_rd", 4'b0000, 32'hDEAD_BEEF, 8'h00, 8'h96, 13);
        force_q = '{4'hF, 4'hF, 4'hF};
        run_txn("no_resp", 4'b0000, 32'h0000_0060, 8'h00, 8'h11, -1);
        force_q = '{4'hA};
        run_txn("sync_err", 4'b0000, 32'h0000_0064, 8'h00, 8'h5A, -1);
        run_txn("unsup", 4'b1000, 32'h0000_0000, 8'h00, 8'h00, 0);

        // reset while the address nibbles are on the bus
        req_valid       = 1'b1;
        req_cyctype_dir = 4'b0000;
        req_addr        = 32'h0000_2E2F;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("rst.in_addr", {30'd0, lpc_frame, lpc_ad_oe}, 32'd3);
        #1 reset = 1'b0;
        #1 check_reset_values("rst.async");
        @(negedge clock);
        reset = 1'b1;
        check("rst.ready_after", {31'd0, req_ready}, 32'd1);
        force_q = '{4'h0};
        run_txn("post_rst", 4'b0000, 32'h0000_2E2F, 8'h00, 8'h7E, 13);

        for (int n = 0; n < 60; n++) begin
            u = $urandom_range(0, 9);
            ct = rnd4();
            if (u < 4)      ct[3:2] = 2'b00;
            else if (u < 8) ct[3:2] = 2'b01;
            else            ct[3]   = 1'b1;
            force_q.delete();
            run_txn($sformatf("rnd%0d", n), ct, $urandom, 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), -1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                check("idle", {28'd0, lpc_frame, lpc_ad_oe, req_ready, resp_valid}, 32'b1010);
            end
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/lpc_host.md
# lpc_host

LPC bus initiator that turns one request record into a complete LPC I/O or memory cycle on the AD/FRAME# pins. It is the transmit-side counterpart of the `lpc` sniffer decoder. It is used as a bench and loopback stimulus source and as a host for peripheral bring-up. The request fields use the sniffer record layout: address[31:0], data[7:0] and cyctype_dir[3:0]. Completion status and read data are returned on a single-cycle response strobe.

## Interface

Parameters:
- `SYNC_TIMEOUT`, default 16: maximum long-wait SYNC cycles before abort. Only used with the timeout macro.

Ports:
- `clock`  in  1  LPC clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  a request is present.
- `req_ready`  out  1  block is idle and can accept a request.
- `req_cyctype_dir`  in  4  LPC cycle type/direction nibble:
  - [3:2]: 00 = I/O, 01 = memory.
  - [1]: 1 = write, 0 = read.
  - [0]: reserved, driven as 0.
- `req_addr`  in  32  address. I/O cycles use [15:0].
- `req_data`  in  8  write data.
- `lpc_ad_out`  out  4  AD value driven by the host.
- `lpc_ad_oe`  out  1  AD output enable.
- `lpc_ad_in`  in  4  sampled AD.
- `lpc_frame`  out  1  FRAME#, active low.
- `resp_valid`  out  1  one-cycle completion strobe.
- `resp_data`  out  8  read data. Valid only with `resp_valid`; holds 0 after a write.
- `resp_error`  out  1  SYNC error, abort or unsupported type. Valid only with `resp_valid`.

## Operation

- A request is accepted when `req_valid && req_ready`. All fields are latched on acceptance.
- States: IDLE, START, CYCTYPE, ADDR, WDATA, TAR_H, TAR_P, SYNC, RDATA, TAR_B, ABORT, DONE.
- IDLE: `req_ready`=1, `lpc_frame`=1, `lpc_ad_oe`=0.
- START: `lpc_frame`=0, AD=0000, oe=1. This is the only state in which FRAME# is low, apart from ABORT.
- CYCTYPE: drive `{cyctype[3:1],1'b0}`.
- ADDR: drive nibbles most-significant first.
  - I/O: 4 nibbles, [15:12] down to [3:0].
  - Memory: 8 nibbles, [31:28] down to [3:0].
  - Nibble counter is 3 bits; it terminates at 3 for I/O and 7 for memory.
- WDATA (writes only): drive 2 nibbles, low nibble first.
- TAR_H: 1 cycle driving 1111 with oe=1. TAR_P: 1 cycle with oe=0. Both go to SYNC.
- SYNC: oe=0; sample `lpc_ad_in` each cycle.
  - 0000: ready. Reads go to RDATA, writes go to TAR_B.
  - 0101 or 0110: wait; stay in SYNC.
  - 1010: error. Treated as ready, with the error flag set.
  - 1111: no response. After 3 consecutive cycles of 1111, go to ABORT.
  - Any other value: treated as 1111.
- RDATA: sample 2 nibbles into `resp_data`, low nibble first.
- TAR_B: 2 cycles with oe=0, then DONE.
- ABORT: `lpc_frame`=0 and AD=1111 with oe=1 for 4 cycles, then 1 cycle of FRAME#=1 with oe=0, then DONE with `resp_error`=1.
- DONE: `resp_valid`=1 for one cycle, then IDLE.
- Unsupported type (req[3:2] = 10 or 11): go directly to DONE with `resp_error`=1 and no bus activity.
- Reset deasserted mid-cycle is not resumed. Any reset assertion returns the block to IDLE immediately; no abort is issued.

## Timing

- All outputs are registered.
- Reset values:
  - `req_ready`=1
  - `lpc_frame`=1
  - `lpc_ad_oe`=0
  - `lpc_ad_out`=1111
  - `resp_valid`=0
  - `resp_data`=0
  - `resp_error`=0
- START is driven in the cycle after acceptance.
- `req_ready` drops in the acceptance cycle's successor and stays low until the cycle after DONE.
- Latency from acceptance to `resp_valid`, with SYNC ready on its first cycle:
  - I/O read and I/O write: 13 cycles.
  - Memory read and memory write: 17 cycles.
  - Each SYNC wait cycle adds 1.
- `lpc_ad_in` is sampled at the clock edge ending each SYNC/RDATA cycle.

## Configuration

- `LPC_HOST_SYNC_TIMEOUT_EN` defined: a 5-bit counter counts consecutive long-wait SYNCs (0110). Reaching `SYNC_TIMEOUT` enters ABORT.
- Not defined: long wait is unbounded. Only the 3-cycle no-response rule aborts.

## Test plan

- I/O write: cyctype 0010, addr 0x0080, data 0xA5, SYNC 0000 on the first cycle. Required:
  - AD sequence 0000, 0010, 0, 0, 8, 0, 5, A, F, then released.
  - `resp_valid` 13 cycles after acceptance, `resp_error`=0.
- Memory read: cyctype 0100, addr 0xFFFFFFF0. Peripheral returns 2 wait-SYNCs (0110), then 0000, then data nibbles 3 and C. Required: `resp_data`=0xC3, `resp_valid` 19 cycles after acceptance.
- No responder (AD pulled to 1111): required 4 cycles of FRAME# low with AD=1111, then `resp_error`=1.
- SYNC 1010 on a read with data 0x5A: required `resp_data`=0x5A, `resp_error`=1.
- Unsupported cyctype 1000: required `resp_valid` and `resp_error` 1 cycle after acceptance, with FRAME# staying high throughout.
- Reset asserted during the ADDR state: required all outputs at reset values asynchronously. After release, `req_ready`=1 and a fresh I/O read completes normally.
